sys_cmd_seq: RTL and testbench

SYS_CMD_SEQ -- requirements
Module: sys_cmd_seq

---
 rtl/sys_cmd_seq_if.sv | 55 +++++
 rtl/sys_cmd_seq.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_sys_cmd_seq.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_cmd_seq_if.sv
// ---------------------------------------------------------------------------
// sys_cmd_seq_if -- bus bundle between the command sequencer and its
// surroundings (UART RX byte stream, register file, ALU, TX FIFO).
//
//   RX_P_DATA / RX_D_VLD       received byte + one-cycle strobe
//   RD_DATA / RD_DATA_VLD      register-file read return
//   ALU_OUT / ALU_OUT_VLD      ALU result return
//   FIFO_FULL                  TX FIFO back-pressure
//   ADDRESS / WR_EN / WR_DATA  register-file write (and read address)
//   RD_EN                      register-file read strobe
//   ALU_FUN / ALU_EN           ALU operation request
//   CLK_GATE_EN                ALU clock-gate enable
//   TX_P_DATA / TX_D_VLD       byte pushed into the TX FIFO
//   CMD_ERR                    one-cycle protocol error pulse
//
// modport slave  : the sequencer side
// modport master : the environment side (RX, register file, ALU, FIFO)
// ---------------------------------------------------------------------------
interface sys_cmd_seq_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR          = 4,
    parameter int ALU_OUT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]    RX_P_DATA;
    logic                     RX_D_VLD;
    logic [DATA_WIDTH-1:0]    RD_DATA;
    logic                     RD_DATA_VLD;
    logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
    logic                     ALU_OUT_VLD;
    logic                     FIFO_FULL;
    logic [ADDR-1:0]          ADDRESS;
    logic                     WR_EN;
    logic [DATA_WIDTH-1:0]    WR_DATA;
    logic                     RD_EN;
    logic [3:0]               ALU_FUN;
    logic                     ALU_EN;
    logic                     CLK_GATE_EN;
    logic [DATA_WIDTH-1:0]    TX_P_DATA;
    logic                     TX_D_VLD;
    logic                     CMD_ERR;

    modport slave (
        input  RX_P_DATA, RX_D_VLD, RD_DATA, RD_DATA_VLD,
               ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
        output ADDRESS, WR_EN, WR_DATA, RD_EN, ALU_FUN, ALU_EN,
               CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
    );

    modport master (
        output RX_P_DATA, RX_D_VLD, RD_DATA, RD_DATA_VLD,
               ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
        input  ADDRESS, WR_EN, WR_DATA, RD_EN, ALU_FUN, ALU_EN,
               CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
    );
endinterface

// File: rtl/sys_cmd_seq.sv
// ---------------------------------------------------------------------------
// sys_cmd_seq -- byte-stream command sequencer.
//
// Decodes framed commands arriving one byte at a time and drives the
// register file, the ALU and the TX FIFO:
//   AA addr data        register write
//   BB addr             register read, read byte returned on TX
//   CC opA opB fun      write operands to regs 0/1, run ALU, result on TX
//   DD fun              run ALU on current regs 0/1, result on TX
// ALU results go out LSB first, then MSB (always both bytes).
//
// Ports:
//   CLK  single clock, all state on the rising edge
//   RST  asynchronous active-high reset
//   bus  sys_cmd_seq_if.slave (see interface file for signal list)
//
// Every output is a register; strobes are high for exactly one cycle,
// the cycle after the input event that qualifies them. Bytes arriving
// while the sequencer is waiting on the register file, the ALU or the
// FIFO are dropped with a CMD_ERR pulse. A frame stalled mid-way for
// TIMEOUT_CYCLES cycles is abandoned with a CMD_ERR pulse.
// ---------------------------------------------------------------------------
module sys_cmd_seq #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR           = 4,
    parameter int ALU_OUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         CLK,
    input  logic         RST,
    sys_cmd_seq_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OP_A,
        ST_OP_B,
        ST_FUN,
        ST_ALU_WAIT,
        ST_TX_LSB,
        ST_TX_MSB,
        ST_TX_RD
    } state_e;

    state_e                   state_q,    state_d;
    logic [ADDR-1:0]          address_q,  address_d;
    logic                     wr_en_q,    wr_en_d;
    logic [DATA_WIDTH-1:0]    wr_data_q,  wr_data_d;
    logic                     rd_en_q,    rd_en_d;
    logic [3:0]               alu_fun_q,  alu_fun_d;
    logic                     alu_en_q,   alu_en_d;
    logic                     clk_gate_q, clk_gate_d;
    logic [DATA_WIDTH-1:0]    tx_data_q,  tx_data_d;
    logic                     tx_vld_q,   tx_vld_d;
    logic                     cmd_err_q,  cmd_err_d;
    logic [DATA_WIDTH-1:0]    rd_byte_q,  rd_byte_d;
    logic [ALU_OUT_WIDTH-1:0] alu_res_q,  alu_res_d;
    logic [CNT_W-1:0]         cnt_q,      cnt_d;

    logic                     rx_vld;
    logic [DATA_WIDTH-1:0]    rx_byte;
    logic                     timed;
    logic                     timeout;

    assign rx_vld  = bus.RX_D_VLD;
    assign rx_byte = bus.RX_P_DATA;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            address_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            rd_en_q    <= 1'b0;
            alu_fun_q  <= '0;
            alu_en_q   <= 1'b0;
            clk_gate_q <= 1'b0;
            tx_data_q  <= '0;
            tx_vld_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            rd_byte_q  <= '0;
            alu_res_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            address_q  <= address_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            alu_fun_q  <= alu_fun_d;
            alu_en_q   <= alu_en_d;
            clk_gate_q <= clk_gate_d;
            tx_data_q  <= tx_data_d;
            tx_vld_q   <= tx_vld_d;
            cmd_err_q  <= cmd_err_d;
            rd_byte_q  <= rd_byte_d;
            alu_res_q  <= alu_res_d;
            cnt_q      <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        rd_en_d    = 1'b0;
        alu_fun_d  = alu_fun_q;
        alu_en_d   = 1'b0;
        tx_data_d  = tx_data_q;
        tx_vld_d   = 1'b0;
        cmd_err_d  = 1'b0;
        rd_byte_d  = rd_byte_q;
        alu_res_d  = alu_res_q;
        cnt_d      = '0;

        // Only the states that wait on the remote sender are guarded by
        // the inter-byte timer; waits on local blocks are unbounded.
        timed = state_q inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
                                ST_OP_A, ST_OP_B, ST_FUN};

        // A byte landing on the expiry cycle wins over the timeout.
        timeout = timed && !rx_vld &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

        if (timed && !rx_vld) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_vld) begin
                    case (rx_byte)
                        CMD_WR:  state_d = ST_WR_ADDR;
                        CMD_RD:  state_d = ST_RD_ADDR;
                        CMD_OP:  state_d = ST_OP_A;
                        CMD_FUN: state_d = ST_FUN;
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end

            ST_WR_ADDR: begin
                if (rx_vld) begin
                    address_d = rx_byte[ADDR-1:0];
                    state_d   = ST_WR_DATA;
                end
            end

            ST_WR_DATA: begin
                if (rx_vld) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = rx_byte;
                    state_d   = ST_IDLE;
                end
            end

            ST_RD_ADDR: begin
                if (rx_vld) begin
                    rd_en_d   = 1'b1;
                    address_d = rx_byte[ADDR-1:0];
                    state_d   = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                cmd_err_d = rx_vld;
                if (bus.RD_DATA_VLD) begin
                    rd_byte_d = bus.RD_DATA;
                    state_d   = ST_TX_RD;
                end
            end

            // Operands land in registers 0 and 1, where the ALU reads them.
            ST_OP_A: begin
                if (rx_vld) begin
                    wr_en_d   = 1'b1;
                    address_d = '0;
                    wr_data_d = rx_byte;
                    state_d   = ST_OP_B;
                end
            end

            ST_OP_B: begin
                if (rx_vld) begin
                    wr_en_d   = 1'b1;
                    address_d = ADDR'(1);
                    wr_data_d = rx_byte;
                    state_d   = ST_FUN;
                end
            end

            ST_FUN: begin
                if (rx_vld) begin
                    alu_fun_d = rx_byte[3:0];
                    alu_en_d  = 1'b1;
                    state_d   = ST_ALU_WAIT;
                end
            end

            // ALU_EN is a level held until the result comes back.
            ST_ALU_WAIT: begin
                cmd_err_d = rx_vld;
                if (bus.ALU_OUT_VLD) begin
                    alu_res_d = bus.ALU_OUT;
                    state_d   = ST_TX_LSB;
                end else begin
                    alu_en_d  = 1'b1;
                end
            end

            ST_TX_LSB: begin
                cmd_err_d = rx_vld;
                if (!bus.FIFO_FULL) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = alu_res_q[DATA_WIDTH-1:0];
                    state_d   = ST_TX_MSB;
                end
            end

            ST_TX_MSB: begin
                cmd_err_d = rx_vld;
                if (!bus.FIFO_FULL) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    state_d   = ST_IDLE;
                end
            end

            ST_TX_RD: begin
                cmd_err_d = rx_vld;
                if (!bus.FIFO_FULL) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = rd_byte_q;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abandoned frame: no strobes were issued above since no byte
        // arrived this cycle, so only the error pulse goes out.
        if (timeout) begin
            cmd_err_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
        end

        // Registered copy of "next state is FUN or ALU_WAIT" so the gate
        // enable lines up exactly with those states.
        clk_gate_d = (state_d == ST_FUN) || (state_d == ST_ALU_WAIT);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ADDRESS     = address_q;
    assign bus.WR_EN       = wr_en_q;
    assign bus.WR_DATA     = wr_data_q;
    assign bus.RD_EN       = rd_en_q;
    assign bus.ALU_FUN     = alu_fun_q;
    assign bus.ALU_EN      = alu_en_q;
    assign bus.CLK_GATE_EN = clk_gate_q;
    assign bus.TX_P_DATA   = tx_data_q;
    assign bus.TX_D_VLD    = tx_vld_q;
    assign bus.CMD_ERR     = cmd_err_q;

endmodule

// File: tb/tb_sys_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_sys_cmd_seq -- scoreboard bench for sys_cmd_seq.
//
// Frame tasks push the expected register writes, reads, ALU requests, TX
// bytes and error pulses into queues as they issue bytes; a monitor pops
// and compares whenever the DUT raises a strobe. An environment block
// plays register file and ALU; a FIFO block supplies back-pressure.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sys_cmd_seq;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int OW = 16;
    localparam int TO = 1024;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    sys_cmd_seq_if #(.DATA_WIDTH(DW), .ADDR(AW), .ALU_OUT_WIDTH(OW)) bus ();

    sys_cmd_seq #(
        .DATA_WIDTH(DW), .ADDR(AW), .ALU_OUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge CLK) cyc++;

    // scoreboard queues
    logic [11:0] q_wr[$];
    logic [3:0]  q_rd[$];
    logic [3:0]  q_alu[$];
    logic [7:0]  q_tx[$];
    int          q_err[$];

    logic [7:0] mdl_mem[16];   // expected register-file contents
    logic [7:0] env_mem[16];   // register file as written by the DUT

    int tx_seen = 0, err_seen = 0;
    int last_tx_cyc = 0, prev_tx_cyc = 0, err_cyc = 0;

    int rd_force = -1, alu_force = -1;
    bit rand_full = 1'b0, hold_req = 1'b0;
    int hold_cnt = 0;

    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] f);
        case (f)
            4'd0:    return {8'h00, a} + {8'h00, b};
            4'd1:    return {8'h00, a} - {8'h00, b};
            4'd2:    return {8'h00, a} * {8'h00, b};
            4'd3:    return {8'h00, a & b};
            4'd4:    return {8'h00, a | b};
            4'd5:    return {8'h00, a ^ b};
            4'd6:    return {a, b};
            default: return {b, a};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic unexp(input string nm, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected strobe, value %0h, nothing expected (t=%0t)", nm, act, $time);
    endtask

    // ---------------- monitor ----------------
    logic alu_prev = 1'b0;
    always @(negedge CLK) begin
        if (RST) begin
            alu_prev = 1'b0;
        end else begin
            if (bus.WR_EN) begin
                if (q_wr.size() == 0) unexp("wr", {bus.ADDRESS, bus.WR_DATA});
                else chk("wr", {20'h0, bus.ADDRESS, bus.WR_DATA}, {20'h0, q_wr.pop_front()});
            end
            if (bus.RD_EN) begin
                if (q_rd.size() == 0) unexp("rd", bus.ADDRESS);
                else chk("rd_addr", bus.ADDRESS, q_rd.pop_front());
            end
            if (bus.ALU_EN && !alu_prev) begin
                if (q_alu.size() == 0) unexp("alu", bus.ALU_FUN);
                else chk("alu_fun", bus.ALU_FUN, q_alu.pop_front());
                chk("cg_alu", bus.CLK_GATE_EN, 1);
            end
            alu_prev = bus.ALU_EN;
            if (bus.TX_D_VLD) begin
                if (q_tx.size() == 0) unexp("tx", bus.TX_P_DATA);
                else chk("tx", bus.TX_P_DATA, q_tx.pop_front());
                tx_seen++;
                prev_tx_cyc = last_tx_cyc;
                last_tx_cyc = cyc;
            end
            if (bus.CMD_ERR) begin
                if (q_err.size() == 0) unexp("cmd_err", 1);
                else void'(q_err.pop_front());
                checks++;
                err_seen++;
                err_cyc = cyc;
            end
        end
    end

    // ---------------- register file / ALU model ----------------
    logic       rd_pend = 1'b0, alu_pend = 1'b0, alu_done = 1'b0;
    int         rd_cnt = 0, alu_cnt = 0;
    logic [3:0] rd_addr = '0;
    always @(negedge CLK) begin
        if (RST) begin
            rd_pend = 0; alu_pend = 0; alu_done = 0;
            bus.RD_DATA_VLD = 0; bus.ALU_OUT_VLD = 0;
            bus.RD_DATA = '0; bus.ALU_OUT = '0;
        end else begin
            bus.RD_DATA_VLD = 0;
            bus.ALU_OUT_VLD = 0;
            if (bus.WR_EN) env_mem[bus.ADDRESS] = bus.WR_DATA;
            if (bus.RD_EN) begin
                rd_pend = 1; rd_addr = bus.ADDRESS;
                rd_cnt = (rd_force >= 0) ? rd_force : int'($urandom_range(0, 3));
            end
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    bus.RD_DATA_VLD = 1; bus.RD_DATA = env_mem[rd_addr]; rd_pend = 0;
                end else rd_cnt--;
            end
            if (!bus.ALU_EN) begin
                alu_pend = 0; alu_done = 0;
            end else if (!alu_pend && !alu_done) begin
                alu_pend = 1;
                alu_cnt = (alu_force >= 0) ? alu_force : int'($urandom_range(0, 4));
            end
            if (alu_pend) begin
                if (alu_cnt == 0) begin
                    bus.ALU_OUT_VLD = 1;
                    bus.ALU_OUT = alu_ref(env_mem[0], env_mem[1], bus.ALU_FUN);
                    alu_pend = 0; alu_done = 1;
                end else alu_cnt--;
            end
        end
    end

    // ---------------- TX FIFO back-pressure ----------------
    always @(negedge CLK) begin
        if (hold_req && bus.TX_D_VLD) begin
            hold_cnt = 10;
            hold_req = 0;
        end
        if (hold_cnt > 0) begin
            bus.FIFO_FULL = 1;
            hold_cnt--;
        end else begin
            bus.FIFO_FULL = rand_full && ($urandom_range(0, 3) == 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        bus.RX_D_VLD  = 1;
        bus.RX_P_DATA = b;
        @(negedge CLK);
        bus.RX_D_VLD  = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic gap();
        idle(int'($urandom_range(0, 3)));
    endtask

    task automatic wait_tx(input int target);
        int k = 0;
        while (tx_seen < target && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        if (tx_seen < target) begin
            checks++; errors++;
            $display("FAIL tx_wait: got %0d bytes expected %0d", tx_seen, target);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        q_wr.push_back({a[3:0], d});
        mdl_mem[a[3:0]] = d;
        send(8'hAA); gap(); send(a); gap(); send(d);
    endtask

    task automatic do_read(input logic [7:0] a);
        int t = tx_seen + 1;
        q_rd.push_back(a[3:0]);
        q_tx.push_back(mdl_mem[a[3:0]]);
        send(8'hBB); gap(); send(a);
        wait_tx(t);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        int t = tx_seen + 2;
        logic [15:0] r = alu_ref(a, b, f[3:0]);
        q_wr.push_back({4'd0, a});
        q_wr.push_back({4'd1, b});
        q_alu.push_back(f[3:0]);
        q_tx.push_back(r[7:0]);
        q_tx.push_back(r[15:8]);
        mdl_mem[0] = a;
        mdl_mem[1] = b;
        send(8'hCC); gap(); send(a); gap(); send(b); gap(); send(f);
        wait_tx(t);
    endtask

    task automatic do_fun(input logic [7:0] f);
        int t = tx_seen + 2;
        logic [15:0] r = alu_ref(mdl_mem[0], mdl_mem[1], f[3:0]);
        q_alu.push_back(f[3:0]);
        q_tx.push_back(r[7:0]);
        q_tx.push_back(r[15:8]);
        send(8'hDD); gap(); send(f);
        wait_tx(t);
    endtask

    task automatic do_bad(input logic [7:0] b);
        q_err.push_back(1);
        send(b);
    endtask

    function automatic logic [29:0] outs();
        return {bus.ADDRESS, bus.WR_EN, bus.WR_DATA, bus.RD_EN, bus.ALU_FUN,
                bus.ALU_EN, bus.CLK_GATE_EN, bus.TX_P_DATA, bus.TX_D_VLD, bus.CMD_ERR};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int c1, e0, t;
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            mdl_mem[i] = 8'h00;
            env_mem[i] = 8'h00;
        end
        bus.RX_D_VLD  = 0;
        bus.RX_P_DATA = '0;

        // reset state
        idle(2);
        chk("reset_outs", {2'b00, outs()}, 0);
        RST = 0;
        idle(2);

        // write 5A to reg 4, read it back
        do_write(8'h04, 8'h5A);
        idle(3);
        do_read(8'h04);
        idle(2);
        chk("cg_idle", bus.CLK_GATE_EN, 0);

        // operand frame with FIFO held full for 10 cycles before the MSB
        idle(3);
        hold_req = 1;
        do_op(8'hA9, 8'hAF, 8'h00);
        chk("msb_delay", last_tx_cyc - prev_tx_cyc, 11);
        idle(3);

        // bad command byte, then a stalled write frame
        do_bad(8'h55);
        idle(2);
        e0 = err_seen;
        q_err.push_back(1);
        send(8'hAA);
        send(8'h03);
        c1 = cyc;
        t = 0;
        while (err_seen == e0 && t < TO + 100) begin
            @(negedge CLK);
            t++;
        end
        chk("timeout_lat", err_cyc - c1, TO);
        idle(2);
        do_fun(8'h02);
        idle(2);

        // byte on the expiry cycle must be accepted
        q_wr.push_back({4'd7, 8'h3C});
        mdl_mem[7] = 8'h3C;
        send(8'hAA); idle(TO - 2);
        send(8'h07); idle(TO - 2);
        send(8'h3C);
        idle(3);

        // byte dropped while waiting on the register file
        rd_force = 6;
        q_rd.push_back(4'd2);
        q_tx.push_back(mdl_mem[2]);
        q_err.push_back(1);
        t = tx_seen + 1;
        send(8'hBB); send(8'h02); send(8'h77);
        wait_tx(t);
        rd_force = -1;
        idle(2);

        // byte dropped while waiting on the ALU
        alu_force = 6;
        r = alu_ref(mdl_mem[0], mdl_mem[1], 4'd3);
        q_alu.push_back(4'd3);
        q_tx.push_back(r[7:0]);
        q_tx.push_back(r[15:8]);
        q_err.push_back(1);
        t = tx_seen + 2;
        send(8'hDD); send(8'h03);
        chk("cg_wait", bus.CLK_GATE_EN, 1);
        send(8'h11);
        wait_tx(t);
        alu_force = -1;
        idle(2);

        // reset while waiting on the ALU; no TX may follow
        alu_force = 40;
        q_alu.push_back(4'd5);
        send(8'hDD); send(8'h05);
        idle(5);
        chk("alu_en_hold", bus.ALU_EN, 1);
        #2 RST = 1;
        #1 chk("reset_mid", {2'b00, outs()}, 0);
        idle(2);
        RST = 0;
        alu_force = -1;
        do_read(8'h04);
        idle(2);

        // randomized frames
        rand_full = 1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: do_write(8'($urandom), 8'($urandom));
                3, 4:    do_read(8'($urandom));
                5, 6:    do_op(8'($urandom), 8'($urandom), 8'($urandom));
                7:       do_fun(8'($urandom));
                default: begin
                    do b = 8'($urandom);
                    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
                    do_bad(b);
                end
            endcase
            gap();
        end
        rand_full = 0;
        idle(20);

        chk("left_wr",  q_wr.size(),  0);
        chk("left_rd",  q_rd.size(),  0);
        chk("left_alu", q_alu.size(), 0);
        chk("left_tx",  q_tx.size(),  0);
        chk("left_err", q_err.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
